ysyx_24110015_ifu: RTL and testbench

YSYX_24110015_IFU -- requirements
Module: ysyx_24110015_ifu

---
 rtl/ysyx_24110015_ifu.sv | 115 +++++++++++
 tb/tb_ysyx_24110015_ifu.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_ifu.sv
// Instruction fetch unit: issues one word-aligned fetch at a time, captures the
// response, and offers it to decode. Redirects from branches, jumps and traps
// replace the PC in any state. Every output comes straight from a register.
module ysyx_24110015_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_req_addr,
   input  logic        mem_rsp_valid,
   input  logic [31:0] mem_rsp_data,
   input  logic        mem_rsp_err,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   output logic        inst_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
);

   typedef enum logic [1:0] {
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        drop;
   logic [31:0] redirect_aligned;

   // A redirect target is always forced onto a word boundary before it is loaded.
   assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

   // The request address is the PC register itself, so it never depends on inputs.
   assign mem_req_addr = pc;

   // Main fetch FSM. The request valid is registered, so it first rises on the
   // first clock edge after reset is released. A redirect overrides pc+4 in every
   // state. The drop flag marks an in-flight response that belongs to a stale PC.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_REQ;
         pc            <= RESET_PC;
         drop          <= 1'b0;
         mem_req_valid <= 1'b0;
         inst_valid    <= 1'b0;
         inst          <= 32'h0;
         inst_pc       <= 32'h0;
         inst_err      <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (redirect_valid) begin
                  pc <= redirect_aligned;
               end
               if (mem_req_valid && mem_req_ready) begin
                  state         <= S_WAIT;
                  mem_req_valid <= 1'b0;
                  drop          <= redirect_valid;
               end else begin
                  mem_req_valid <= 1'b1;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  pc <= redirect_aligned;
                  if (mem_rsp_valid) begin
                     state         <= S_REQ;
                     drop          <= 1'b0;
                     mem_req_valid <= 1'b1;
                  end else begin
                     drop <= 1'b1;
                  end
               end else if (mem_rsp_valid) begin
                  if (drop) begin
                     state         <= S_REQ;
                     drop          <= 1'b0;
                     mem_req_valid <= 1'b1;
                  end else begin
                     state      <= S_HOLD;
                     inst       <= mem_rsp_data;
                     inst_err   <= mem_rsp_err;
                     inst_pc    <= pc;
                     inst_valid <= 1'b1;
                  end
               end
            end
            S_HOLD: begin
               if (redirect_valid) begin
                  pc            <= redirect_aligned;
                  state         <= S_REQ;
                  inst_valid    <= 1'b0;
                  mem_req_valid <= 1'b1;
               end else if (inst_ready) begin
                  pc            <= pc + 32'd4;
                  state         <= S_REQ;
                  inst_valid    <= 1'b0;
                  mem_req_valid <= 1'b1;
               end
            end
            default: begin
               state         <= S_REQ;
               drop          <= 1'b0;
               mem_req_valid <= 1'b0;
               inst_valid    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_24110015_ifu.sv
// Testbench for the fetch unit: directed cycle-by-cycle vectors, a transaction
// level reference model compared every cycle, and hand-computed spot checks.
module tb_ysyx_24110015_ifu;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clock;
   logic        reset_n;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_rsp_valid;
   logic [31:0] mem_rsp_data;
   logic        mem_rsp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_err;
   logic        redirect_valid;
   logic [31:0] redirect_pc;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   ysyx_24110015_ifu #(.RESET_PC(RESET_PC)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_rsp_valid  (mem_rsp_valid),
      .mem_rsp_data   (mem_rsp_data),
      .mem_rsp_err    (mem_rsp_err),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_err       (inst_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model in transaction terms: whether the unit has started issuing,
   // whether a request is in flight and still wanted, and whether an instruction
   // is being held for decode.
   logic [31:0] m_pc, m_inst, m_ipc;
   logic        m_ierr, m_started, m_out, m_drop, m_hold;
   logic        m_offering, m_accepted, m_answered, m_was_hold;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_pc      = RESET_PC;
         m_started = 1'b0;
         m_out     = 1'b0;
         m_drop    = 1'b0;
         m_hold    = 1'b0;
         m_inst    = 32'h0;
         m_ipc     = 32'h0;
         m_ierr    = 1'b0;
      end else begin
         m_offering = m_started && !m_out && !m_hold;
         m_accepted = m_offering && mem_req_ready;
         m_answered = m_out && mem_rsp_valid;
         m_was_hold = m_hold;
         if (m_answered) begin
            if (!m_drop && !redirect_valid) begin
               m_hold = 1'b1;
               m_inst = mem_rsp_data;
               m_ierr = mem_rsp_err;
               m_ipc  = m_pc;
            end
            m_out  = 1'b0;
            m_drop = 1'b0;
         end else if (m_out && redirect_valid) begin
            m_drop = 1'b1;
         end
         if (m_accepted) begin
            m_out  = 1'b1;
            m_drop = redirect_valid;
         end
         if (m_was_hold && (inst_ready || redirect_valid)) begin
            m_hold = 1'b0;
            if (!redirect_valid) m_pc = m_pc + 32'd4;
         end
         if (redirect_valid) m_pc = {redirect_pc[31:2], 2'b00};
         m_started = 1'b1;
      end
   end

   // Shared comparison helper; every check goes through here.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
      end
   endtask

   // Per-cycle comparison of every DUT output against the model, taken just after the falling edge.
   always @(negedge clock) begin
      #1;
      if (check_en) begin
         checkOutput("mem_req_valid", {31'h0, mem_req_valid}, {31'h0, (m_started && !m_out && !m_hold)});
         checkOutput("mem_req_addr", mem_req_addr, m_pc);
         checkOutput("inst_valid", {31'h0, inst_valid}, {31'h0, m_hold});
         checkOutput("inst", inst, m_inst);
         checkOutput("inst_pc", inst_pc, m_ipc);
         checkOutput("inst_err", {31'h0, inst_err}, {31'h0, m_ierr});
      end
   end

   // Drive one cycle of inputs at a falling edge, then wait for the next falling edge.
   task automatic applyStimulus(input logic rdy, input logic rspv, input logic [31:0] data,
                                input logic err, input logic irdy, input logic redir,
                                input logic [31:0] rpc);
      mem_req_ready  = rdy;
      mem_rsp_valid  = rspv;
      mem_rsp_data   = data;
      mem_rsp_err    = err;
      inst_ready     = irdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      @(negedge clock);
   endtask

   initial begin
      reset_n        = 1'b0;
      mem_req_ready  = 1'b0;
      mem_rsp_valid  = 1'b0;
      mem_rsp_data   = 32'h0;
      mem_rsp_err    = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      check_en       = 1'b1;
      repeat (2) @(negedge clock);
      checkOutput("reset_req_valid", {31'h0, mem_req_valid}, 32'h0);
      checkOutput("reset_inst_pc", inst_pc, 32'h0);
      reset_n = 1'b1;

      // Zero-wait memory with decode always ready: three fetches, one every third cycle.
      applyStimulus(1, 0, 0, 0, 1, 0, 0);
      checkOutput("first_req_valid", {31'h0, mem_req_valid}, 32'h1);
      checkOutput("first_req_addr", mem_req_addr, 32'h8000_0000);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1, 0, 0, 0, 1, 0, 0);
         checkOutput("hs_req_dropped", {31'h0, mem_req_valid}, 32'h0);
         applyStimulus(1, 1, 32'h0000_0013, 0, 1, 0, 0);
         checkOutput("seq_inst_valid", {31'h0, inst_valid}, 32'h1);
         checkOutput("seq_inst_pc", inst_pc, 32'h8000_0000 + 32'(4 * k));
         checkOutput("seq_inst", inst, 32'h0000_0013);
         applyStimulus(1, 0, 0, 0, 1, 0, 0);
         checkOutput("seq_next_addr", mem_req_addr, 32'h8000_0004 + 32'(4 * k));
      end

      // Decode stalls for five cycles: instruction held, no new request.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 32'h0010_0093, 0, 0, 0, 0);
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1, 0, 0, 0, 0, 0, 0);
         checkOutput("stall_inst_pc", inst_pc, 32'h8000_000C);
         checkOutput("stall_inst", inst, 32'h0010_0093);
         checkOutput("stall_no_req", {31'h0, mem_req_valid}, 32'h0);
      end
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("stall_release_addr", mem_req_addr, 32'h8000_0010);

      // Redirect during WAIT, response two cycles later is dropped.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 1, 32'h8000_0102);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 32'hBAD0_0BAD, 0, 1, 0, 0);
      checkOutput("drop_no_inst", {31'h0, inst_valid}, 32'h0);
      checkOutput("drop_next_addr", mem_req_addr, 32'h8000_0100);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 32'h0000_0073, 0, 0, 0, 0);
      checkOutput("redir_inst_pc", inst_pc, 32'h8000_0100);

      // Redirect in HOLD without acceptance, straight to the top of the address space.
      applyStimulus(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      checkOutput("hold_redir_valid", {31'h0, inst_valid}, 32'h0);
      checkOutput("hold_redir_addr", mem_req_addr, 32'hFFFF_FFFC);

      // Access fault at the last word; pc+4 wraps to zero.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 32'h0, 1, 0, 0, 0);
      checkOutput("err_inst_valid", {31'h0, inst_valid}, 32'h1);
      checkOutput("err_inst_err", {31'h0, inst_err}, 32'h1);
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      checkOutput("wrap_addr", mem_req_addr, 32'h0000_0000);

      // Redirect in REQ without handshake, with a stray response that must be ignored.
      applyStimulus(0, 1, 32'h0000_1234, 0, 0, 1, 32'h0000_1003);
      checkOutput("req_redir_addr", mem_req_addr, 32'h0000_1000);
      checkOutput("stray_rsp_ignored", {31'h0, inst_valid}, 32'h0);
      // Redirect coincident with handshake, then the stale response is discarded.
      applyStimulus(1, 0, 0, 0, 0, 1, 32'h0000_2000);
      applyStimulus(0, 1, 32'h0000_5555, 0, 0, 0, 0);
      checkOutput("hs_redir_drop", {31'h0, inst_valid}, 32'h0);
      // Redirect coincident with a response in WAIT.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 32'h0000_6666, 0, 0, 1, 32'h0000_3000);
      checkOutput("wait_rsp_redir_addr", mem_req_addr, 32'h0000_3000);
      // Redirect in HOLD with decode accepting: redirect wins over pc+4.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 32'h0000_7777, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 32'h0000_4000);
      checkOutput("redir_priority_addr", mem_req_addr, 32'h0000_4000);

      // Reset pulse while waiting, stale response afterwards.
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_req_valid", {31'h0, mem_req_valid}, 32'h0);
      checkOutput("midreset_addr", mem_req_addr, RESET_PC);
      checkOutput("midreset_inst_pc", inst_pc, 32'h0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;
      applyStimulus(0, 1, 32'h0000_DEAD, 0, 1, 0, 0);
      checkOutput("stale_rsp_ignored", {31'h0, inst_valid}, 32'h0);
      checkOutput("post_reset_addr", mem_req_addr, 32'h8000_0000);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 1, 32'h0000_0013, 0, 0, 0, 0);
      checkOutput("post_reset_inst_pc", inst_pc, 32'h8000_0000);
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);

      check_en = 1'b0;
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
